icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/icache_if.sv | 28 ++
 rtl/icache.sv | 102 ++++++++++
 tb/tb_icache.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the instruction cache.
//   word_t          : 32-bit machine word
//   ICACHE_SETS     : default number of direct-mapped frames
//   icache_frame_t  : one cache frame (valid, tag, data word)
//   icache_state_t  : cache controller states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;

    // The tag field is sized for the smallest legal cache (2 sets, 29-bit
    // tag). Larger caches store their narrower tag zero-extended, so the
    // unused upper bits are constant and trim away.
    localparam int ICACHE_TAG_MAX_W = 29;

    typedef struct packed {
        logic                        valid;
        logic [ICACHE_TAG_MAX_W-1:0] tag;
        word_t                       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Instruction cache bus bundle.
//   Datapath side : imemREN, imemaddr (to cache); ihit, imemload (from cache)
//   Memory side   : iREN, iaddr (from cache); iwait, iload (to cache)
// Modport slave is the cache's view; modport master is the view of whatever
// drives the datapath request and answers the memory request.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
//   CLK : rising-edge clock
//   RST : asynchronous active-high reset (clears valid bits, FSM, miss address)
//   bus : icache_if.slave -- datapath request/response and memory fill port
// Hits are answered combinationally in IDLE. A miss latches the word address
// and moves to FETCH, which holds iREN until iwait drops, writes the frame on
// that edge and returns to IDLE, where the request is re-evaluated and hits.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic     CLK,
    input  logic     RST,
    icache_if.slave  bus
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    icache_state_t state_reg, state_next;
    word_t         miss_addr_reg, miss_addr_next;
    logic          fill_en;

    logic [IW-1:0] rd_index, fill_index;
    logic [TW-1:0] rd_tag, fill_tag;

    icache_frame_t frames [SETS];

    // Byte-offset bits of the request are meaningless for word fetches.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.imemaddr[1:0];

    assign rd_index   = bus.imemaddr[IW+1:2];
    assign rd_tag     = bus.imemaddr[31:IW+2];
    assign fill_index = miss_addr_reg[IW+1:2];
    assign fill_tag   = miss_addr_reg[31:IW+2];

    // One register per frame. Only the valid bit is reset; tag and data are
    // qualified by it and need no reset.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_frame
        icache_frame_t frame_reg;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                frame_reg.valid <= 1'b0;
            end else if (fill_en && fill_index == IW'(gi)) begin
                frame_reg <= '{valid: 1'b1,
                               tag:   ICACHE_TAG_MAX_W'(fill_tag),
                               data:  bus.iload};
            end
        end

        assign frames[gi] = frame_reg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            miss_addr_reg <= miss_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        miss_addr_next = miss_addr_reg;
        fill_en        = 1'b0;
        bus.ihit       = 1'b0;
        bus.imemload   = '0;
        bus.iREN       = 1'b0;
        bus.iaddr      = '0;

        case (state_reg)
            IDLE: begin
                bus.ihit = bus.imemREN && frames[rd_index].valid &&
                           frames[rd_index].tag == ICACHE_TAG_MAX_W'(rd_tag);
                if (bus.ihit) begin
                    bus.imemload = frames[rd_index].data;
                end else if (bus.imemREN) begin
                    miss_addr_next = {bus.imemaddr[31:2], 2'b00};
                    state_next     = FETCH;
                end
            end
            FETCH: begin
                // The fill always completes for the latched address, whatever
                // the datapath does meanwhile; IDLE always follows a fill, so
                // back-to-back iREN requests cannot occur.
                bus.iREN  = 1'b1;
                bus.iaddr = miss_addr_reg;
                if (!bus.iwait) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random
// reads, all predicted by a frame-level reference model (valid / word
// address / data per set).
module tb_icache;
    import cpu_types_pkg::*;

    localparam int SETS = 16;

    logic CLK;
    logic RST;

    icache_if bus();

    icache #(.SETS(SETS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each set currently holds.
    bit          m_valid [SETS];
    logic [29:0] m_word  [SETS];
    word_t       m_data  [SETS];

    task automatic check(input string name, input word_t obs, input word_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One datapath read of addr. On a miss, memory answers after lat cycles
    // with data; during the fetch the datapath shows alt_addr/alt_ren, and it
    // returns to addr after the fill to observe the hit.
    task automatic do_read(input word_t addr, input int lat, input word_t data,
                           input word_t alt_addr, input logic alt_ren);
        word_t waddr;
        int    idx;
        bit    hit;
        waddr = {addr[31:2], 2'b00};
        idx   = int'(addr[31:2] % SETS);
        hit   = m_valid[idx] && (m_word[idx] == addr[31:2]);

        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        bus.iload    = $urandom;
        #2;
        check("lookup_ihit", 32'(bus.ihit), 32'(hit));
        check("lookup_iREN", 32'(bus.iREN), 32'd0);
        check("lookup_iaddr", bus.iaddr, 32'd0);
        if (hit) begin
            check("hit_imemload", bus.imemload, m_data[idx]);
            $display("read %h: hit  data %h", addr, bus.imemload);
            tick();
        end else begin
            check("miss_imemload", bus.imemload, 32'd0);
            tick();
            for (int k = 0; k < lat; k++) begin
                bus.imemaddr = alt_addr;
                bus.imemREN  = alt_ren;
                bus.iwait    = (k != lat - 1);
                bus.iload    = (k == lat - 1) ? data : word_t'($urandom);
                #2;
                check("fetch_iREN", 32'(bus.iREN), 32'd1);
                check("fetch_iaddr", bus.iaddr, waddr);
                check("fetch_ihit", 32'(bus.ihit), 32'd0);
                tick();
            end
            m_valid[idx] = 1'b1;
            m_word[idx]  = addr[31:2];
            m_data[idx]  = data;
            bus.imemREN  = 1'b1;
            bus.imemaddr = addr;
            bus.iwait    = 1'b1;
            #2;
            check("fill_ihit", 32'(bus.ihit), 32'd1);
            check("fill_imemload", bus.imemload, data);
            check("fill_iREN", 32'(bus.iREN), 32'd0);
            $display("read %h: miss lat %0d data %h -> %h", addr, lat, data, bus.imemload);
            tick();
        end
    endtask

    initial begin
        word_t a, alt;
        logic  ren;
        int    w;

        model_reset();
        RST          = 1'b1;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h40;
        bus.iwait    = 1'b1;
        bus.iload    = '0;

        // Reset state: nothing valid, no memory request.
        #2;
        check("rst_ihit", 32'(bus.ihit), 32'd0);
        check("rst_imemload", bus.imemload, 32'd0);
        check("rst_iREN", 32'(bus.iREN), 32'd0);
        check("rst_iaddr", bus.iaddr, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        $display("reset released");

        // Cold miss then hits on the same word with differing byte offsets.
        do_read(32'h40, 1, 32'h8C220004, 32'h40, 1'b1);
        do_read(32'h40, 1, 32'h0, 32'h40, 1'b1);
        do_read(32'h43, 1, 32'h0, 32'h43, 1'b1);

        // Conflict eviction: 0x80 shares index 0 with 0x40.
        do_read(32'h80, 2, 32'hDEADBEEF, 32'h80, 1'b1);
        do_read(32'h80, 1, 32'h0, 32'h80, 1'b1);
        do_read(32'h40, 1, 32'h8C220004, 32'h40, 1'b1);

        // No request: a valid frame must not be reported.
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h40;
        #2;
        check("noreq_ihit", 32'(bus.ihit), 32'd0);
        check("noreq_imemload", bus.imemload, 32'd0);
        tick();
        #2;
        check("noreq_iREN", 32'(bus.iREN), 32'd0);
        $display("idle read 00000040 with imemREN=0: ihit %b", bus.ihit);
        tick();

        // Long fetch with the request address changing underneath it.
        do_read(32'h100, 6, 32'h12345678, 32'h200, 1'b1);
        do_read(32'h200, 1, 32'hCAFEF00D, 32'h200, 1'b1);
        do_read(32'h100, 1, 32'h12345678, 32'h100, 1'b1);

        // Reset in the middle of a fetch aborts it at once.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h10;
        bus.iwait    = 1'b1;
        tick();
        #1;
        check("abort_pre_iREN", 32'(bus.iREN), 32'd1);
        RST = 1'b1;
        #1;
        check("abort_iREN", 32'(bus.iREN), 32'd0);
        check("abort_iaddr", bus.iaddr, 32'd0);
        check("abort_ihit", 32'(bus.ihit), 32'd0);
        $display("reset asserted mid-fetch of 00000010: iREN %b", bus.iREN);
        model_reset();
        tick();
        RST = 1'b0;
        do_read(32'h10, 1, 32'hA5A50010, 32'h10, 1'b1);
        do_read(32'h40, 1, 32'h8C220004, 32'h40, 1'b1);

        // Random reads over a small address pool so hits and conflicts mix.
        for (int t = 0; t < 200; t++) begin
            w = $urandom_range(0, 63);
            a = (word_t'(w) << 2) | word_t'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            if ($urandom_range(0, 2) == 0) begin
                alt = word_t'($urandom) & 32'h0000_0FFF;
                ren = 1'($urandom_range(0, 1));
            end else begin
                alt = a;
                ren = 1'b1;
            end
            do_read(a, $urandom_range(1, 4), word_t'($urandom), alt, ren);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
